// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store; one access in flight.
// Latency: strobes one cycle after the IDLE grant, ack combinational with mem_rdy; one IDLE cycle between accesses.
// Backpressure: requesters hold until ack/err and freeze on stall; watchdog aborts hung accesses with err.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              if_err,
    output logic              d_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t     state;
    logic       op_wr;
    logic [3:0] starve_cnt;
    logic [7:0] wd_cnt;

    logic d_req;
    logic grant_d;
    logic grant_if;
    logic wd_limit;

    assign d_req = d_rd | d_wr;

    // No grant during the err pulse: the aborted requester still holds its request that cycle.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && !if_err && !d_err) begin
            grant_d  = d_req && ((starve_cnt < 4'(MAX_STARVE)) || !if_req);
            grant_if = if_req && !grant_d;
        end
    end

    assign wd_limit = (wd_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_wr      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            if_err     <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            if_err <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= BUSY_D;
                        mem_addr <= d_addr;
                        op_wr    <= d_wr;
                        wd_cnt   <= '0;
                        if (d_wr)
                            mem_wdata <= d_wdata;
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt < 4'(MAX_STARVE))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (grant_if) begin
                        state      <= BUSY_IF;
                        mem_addr   <= if_addr;
                        op_wr      <= 1'b0;
                        wd_cnt     <= '0;
                        starve_cnt <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (mem_rdy) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                        if (wd_limit) begin
                            state  <= IDLE;
                            if_err <= (state == BUSY_IF);
                            d_err  <= (state == BUSY_D);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read  = (state == BUSY_IF) || (state == BUSY_D && !op_wr);
    assign mem_write = (state == BUSY_D) && op_wr;

    assign if_ack   = (state == BUSY_IF) && mem_rdy;
    assign d_ack    = (state == BUSY_D) && mem_rdy;
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_rdata  = d_ack ? mem_rdata : '0;

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch unit and the data load/store path. It runs one memory transaction at a time through a small FSM and gives data accesses priority, with a starvation guard for fetch. A watchdog aborts transactions the memory never completes. It sits between the fetch/datapath stage and the memory, and its per-port stall outputs freeze the PC and pipeline while a port waits.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 16, memory word width
- MAX_STARVE, 3, consecutive data grants allowed while fetch is pending before fetch is forced (1..15)
- TIMEOUT, 15, cycles in a busy state without mem_rdy before abort (1..255)

- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack or if_err
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch complete this cycle
- if_rdata  out  DATA_W  fetch data, valid with if_ack
- if_stall  out  1  if_req & ~if_ack
- d_rd, d_wr  in  1 each  data read / write request; held until d_ack or d_err
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  data access complete this cycle
- d_rdata  out  DATA_W  load data, valid with d_ack on reads
- d_stall  out  1  (d_rd|d_wr) & ~d_ack
- mem_addr  out  ADDR_W  registered address to memory
- mem_wdata  out  DATA_W  registered write data
- mem_read, mem_write  out  1 each  memory strobes
- mem_rdata  in  DATA_W  memory read data
- mem_rdy  in  1  memory completes the current access this cycle
- if_err, d_err  out  1 each  one-cycle timeout pulse on the owning port

## Operation
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - With a data request present and starve_cnt < MAX_STARVE, or with no fetch request: grant data and go to BUSY_D.
  - Otherwise, with if_req: grant fetch and go to BUSY_IF.
  - With no request: stay in IDLE.
- On grant, register the granted address into mem_addr, register d_wdata into mem_wdata for data writes, and set the operation register.
- Data operation: d_wr takes precedence over d_rd if both are high. That access is a write and the read is dropped.
- Strobes:
  - mem_read = BUSY_IF | (BUSY_D & op==read).
  - mem_write = BUSY_D & op==write.
  - Both strobes are decoded from registered state only.
- Completion: in BUSY_x with mem_rdy=1, x_ack=1 combinationally that cycle. x_rdata passes mem_rdata through. Next state is IDLE.
- Outside an ack, if_rdata and d_rdata drive 0.
- starve_cnt (4 bits):
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant or when if_req=0 at a data grant.
  - Saturates at MAX_STARVE.
- wd_cnt (8 bits):
  - Clears on every grant and increments each BUSY cycle without mem_rdy.
  - When it reaches TIMEOUT with mem_rdy still 0: pulse x_err for one cycle, drop the strobes, go to IDLE, no ack.
  - mem_rdy in the same cycle as the limit wins: ack is given, not err.
- mem_rdy in IDLE is ignored.
- Requesters change requests only on the cycle after ack or err. The arbiter never re-grants a transaction within the ack cycle.

## Timing
- Reset values: state IDLE, mem_addr=0, mem_wdata=0, starve_cnt=0, wd_cnt=0. Every output is 0 except the stalls, which follow their equations (e.g. if_stall=1 if if_req is held high during reset).
- Cycle 0: request seen in IDLE.
- Cycle 1: strobes valid. With mem_rdy=1 in cycle 1, the ack comes in cycle 1, so minimum latency is 1 cycle after the request.
- Back-to-back transactions have one IDLE cycle between them, giving a throughput of 1 access per 2 cycles with a zero-wait memory.
- Both requests in IDLE: data wins unless starve_cnt==MAX_STARVE.
- Reset asserted mid-transaction: asynchronous return to the reset values, no ack or err, and the transaction is lost.

## Test plan
- Single fetch: if_req=1, if_addr=0x010, mem_rdy=1 in cycle 1 with mem_rdata=0xBEEF -> mem_read=1 and mem_addr=0x010 in cycle 1; if_ack=1 and if_rdata=0xBEEF in cycle 1; if_stall=1 in cycle 0 only.
- Data write with 2 wait states: d_wr=1, d_addr=0x3F0, d_wdata=0x1234, mem_rdy high in the 3rd BUSY cycle -> mem_write=1 for 3 cycles, d_ack in cycle 3, mem_read never asserted.
- Contention and starvation with MAX_STARVE=3: if_req and d_rd held continuously (data re-requested after each ack) -> grant order D,D,D,IF,D,D,D,IF; fetch is never delayed by more than 3 data transactions.
- Simultaneous d_rd=d_wr=1 -> write performed, mem_read=0, d_ack given.
- Timeout with TIMEOUT=15: fetch with mem_rdy held 0 -> if_err pulses 1 cycle after 15 BUSY cycles, no if_ack, state returns to IDLE; mem_rdy=1 exactly on the 15th cycle -> if_ack instead of if_err.
- Reset mid-operation: rst asserted in the 2nd cycle of BUSY_D -> mem_write drops immediately, no ack after release; the pending request is granted afresh once rst falls.
